// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO behind the UART receiver
// Buffers received characters with full/empty/almost-full flags, fill count and sticky overrun.
module uart_rx_fifo #(
  parameter int DBIT     = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              rd,
  output logic [DBIT-1:0]   r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_ok;
  logic              wr_ok;

  // Flags come straight from the count register so they never glitch on next-state logic.
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AF_C);

  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign rd_ok  = rd & ~empty;
  assign wr_ok  = wr & (~full | rd_ok);
  assign r_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (wr_ok && !rd_ok) begin
        count <= count + (ADDR_W+1)'(1);
      end else if (rd_ok && !wr_ok) begin
        count <= count - (ADDR_W+1)'(1);
      end
      // Set has priority over a simultaneous clear.
      if (wr && full && !rd) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - table-driven self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic       rd;
  logic       clr_overrun;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overrun;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DBIT(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
    .clk(clk),
    .reset(reset),
    .wr(wr),
    .w_data(w_data),
    .rd(rd),
    .r_data(r_data),
    .empty(empty),
    .full(full),
    .almost_full(almost_full),
    .count(count),
    .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] wd;
    logic       e;
    logic       f;
    logic       af;
    logic [4:0] cnt;
    logic       ov;
    logic       chk;
    logic [7:0] rdat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int w, input int r, input int c, input int wd,
                              input int e, input int f, input int af, input int cnt,
                              input int ov, input int chk, input int rdat);
    vec_t v;
    v.wr   = w[0];
    v.rd   = r[0];
    v.clr  = c[0];
    v.wd   = wd[7:0];
    v.e    = e[0];
    v.f    = f[0];
    v.af   = af[0];
    v.cnt  = cnt[4:0];
    v.ov   = ov[0];
    v.chk  = chk[0];
    v.rdat = rdat[7:0];
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycle(input logic w, input logic r, input logic c, input logic [7:0] d);
    wr = w; rd = r; clr_overrun = c; w_data = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; clr_overrun = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".empty"},       empty,       1);
    check({tag, ".full"},        full,        0);
    check({tag, ".almost_full"}, almost_full, 0);
    check({tag, ".count"},       count,       0);
    check({tag, ".overrun"},     overrun,     0);
  endtask

  initial begin
    int head;
    logic [7:0] d;

    reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_overrun = 1'b0; w_data = 8'h00;

    // single character
    add(1,0,0,8'hA5, 0,0,0,1,0, 1,8'hA5);
    add(0,0,0,0,     0,0,0,1,0, 1,8'hA5);
    add(0,1,0,0,     1,0,0,0,0, 0,0);
    // fill to full, head stays 8'h00
    for (int i = 0; i < 16; i++)
      add(1,0,0,i, 0,(i==15),((i+1)>=12),i+1,0, 1,8'h00);
    // overrun drop, clear, set-wins, clear
    add(1,0,0,8'hFF, 0,1,1,16,1, 1,8'h00);
    add(0,0,1,0,     0,1,1,16,0, 1,8'h00);
    add(1,0,1,8'hFF, 0,1,1,16,1, 1,8'h00);
    add(0,0,1,0,     0,1,1,16,0, 1,8'h00);
    // simultaneous rd/wr while full: 8'h00 leaves, 8'h55 joins the tail
    add(1,1,0,8'h55, 0,1,1,16,0, 1,8'h01);
    // drain: 01..0F then 55
    for (int k = 0; k < 16; k++) begin
      head = (k + 1 < 15) ? k + 2 : 8'h55;
      add(0,1,0,0, (k==15),0,((15-k)>=12),15-k,0, (k<15),head);
    end
    add(0,1,0,0,     1,0,0,0,0, 0,0);
    add(1,1,0,8'h33, 0,0,0,1,0, 1,8'h33);
    add(0,1,0,0,     1,0,0,0,0, 0,0);

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("in_reset");
    reset = 1'b0;
    #1;
    check_reset_state("after_reset");

    foreach (vecs[i]) begin
      cycle(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].wd);
      check($sformatf("v%0d.empty", i),       empty,       vecs[i].e);
      check($sformatf("v%0d.full", i),        full,        vecs[i].f);
      check($sformatf("v%0d.almost_full", i), almost_full, vecs[i].af);
      check($sformatf("v%0d.count", i),       count,       vecs[i].cnt);
      check($sformatf("v%0d.overrun", i),     overrun,     vecs[i].ov);
      if (vecs[i].chk) check($sformatf("v%0d.r_data", i), r_data, vecs[i].rdat);
    end

    // pointer wrap with one entry in flight
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(0, 255));
      cycle(1'b1, 1'b0, 1'b0, d);
      check($sformatf("wrap%0d.count1", i), count,  1);
      check($sformatf("wrap%0d.r_data", i), r_data, d);
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      check($sformatf("wrap%0d.count0", i), count, 0);
      check($sformatf("wrap%0d.empty", i),  empty, 1);
    end

    // reset mid-operation with count=7 and overrun set
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
    cycle(1'b1, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check("pre_reset.count",   count,   7);
    check("pre_reset.overrun", overrun, 1);
    check("pre_reset.r_data",  r_data,  8'h09);
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("mid_reset");
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_state("post_mid_reset");
    cycle(1'b1, 1'b0, 1'b0, 8'h3C);
    check("post_reset_wr.count",  count,  1);
    check("post_reset_wr.empty",  empty,  0);
    check("post_reset_wr.r_data", r_data, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer placed directly after the UART receiver: captures each received character on the receiver's one-cycle done pulse and holds it until the host side reads it. First-word-fall-through FIFO with full/empty/almost-full flags, a fill count, and a sticky overrun flag. It decouples the bit-rate receiver from slower or bursty consumers such as a bus interface or command parser.

## Interface

Parameters:
- DBIT, 8, character width; must match the receiver's data width.
- ADDR_W, 4, address width; depth = 2**ADDR_W, default 16 entries.
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr  in  1  write strobe; connect to the receiver's rx_done_tick, one cycle per character.
- w_data  in  DBIT  character to store; connect to the receiver's rx_dout; sampled when wr=1.
- rd  in  1  read/pop strobe from the consumer; one entry popped per cycle with rd=1.
- r_data  out  DBIT  head-of-queue character; valid whenever empty=0.
- empty  out  1  no entries stored.
- full  out  1  2**ADDR_W entries stored.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  ADDR_W+1  number of stored entries, 0..2**ADDR_W.
- overrun  out  1  sticky: set when a write was dropped because the FIFO was full.
- clr_overrun  in  1  synchronous clear of overrun.

## Operation

- Storage: 2**ADDR_W x DBIT register array, write pointer and read pointer, each ADDR_W bits and wrapping modulo depth. The array is not reset.
- Occupancy is tracked as an (ADDR_W+1)-bit count register. full = (count == 2**ADDR_W). empty = (count == 0). Both flags are registered or derived directly from the count register, never from next-state logic.
- Write accepted = wr & (~full | rd_accepted). An accepted write stores w_data at wr_ptr, and wr_ptr advances by 1 (modulo depth).
- Read accepted = rd & ~empty. An accepted read advances rd_ptr by 1 (modulo depth). rd while empty is ignored, with no state change and no error flag.
- r_data = mem[rd_ptr], read combinationally (first-word-fall-through). Its value while empty=1 is unspecified and must not be checked.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous rd and wr:
  - When empty: only the write happens, since the read is ignored. Count goes 0 to 1.
  - When full: both happen, count stays at 2**ADDR_W, no overrun, and the new character lands in the slot just freed.
  - Otherwise: both happen and count is unchanged.
- Overrun: wr & full & ~rd sets overrun and drops w_data; stored contents are untouched. overrun stays set until clr_overrun=1. If a set and a clear occur in the same cycle, the set wins.
- Reset mid-operation: all pointers, count and flags return to their reset values immediately (asynchronously). Stored data is discarded logically.

## Timing

- Reset values: empty=1, full=0, almost_full=0, count=0, overrun=0, wr_ptr=rd_ptr=0.
- Write latency: a write accepted at edge N makes empty fall, updates count, and presents r_data for that entry from just after edge N. The consumer can pop it at edge N+1.
- Read: a pop at edge N presents the next entry on r_data just after edge N. If that pop empties the FIFO, empty rises just after edge N.
- Flag timing: full, almost_full and overrun all change just after the edge that causes them, with no extra pipeline stage.
- Throughput: one write and one read per cycle sustained. The receiver writes at most once per character time, so any consumer that keeps up on average never overruns.

## Test plan

- Reset then single character: after reset check empty=1, count=0, overrun=0. Pulse wr with w_data=8'hA5. On the next cycle check empty=0, count=1, r_data=8'hA5. Pulse rd. Then check empty=1, count=0.
- Fill to full with ordering: write 16 characters 8'h00..8'h0F with no reads.
  - almost_full rises after the 12th write.
  - full=1 after the 16th write, with count=16.
  - Then read all 16: they return 8'h00..8'h0F in order, full falls after the first read, and empty=1 at the end.
- Overrun: with the FIFO full, write 8'hFF with rd=0.
  - overrun=1, count stays 16, and the contents read back 8'h00..8'h0F (8'hFF absent).
  - Pulse clr_overrun: overrun=0.
  - Also drive a set and a clear in the same cycle: overrun must stay 1.
- Simultaneous rd/wr:
  - When full: wr=8'h55 with rd=1 gives count=16, no overrun, and 8'h55 read out last.
  - When empty: wr=8'h33 with rd=1 gives count=1 and r_data=8'h33.
- Pointer wrap: perform 40 write/read pairs with random data, one entry in flight. Every read must match the data written, and count must alternate 1/0.
- Reset mid-operation: with count=7 and overrun=1, assert reset between clock edges. All outputs return to their reset values immediately. After release, write 8'h3C: it must read back as 8'h3C with count=1.
